// File: rtl/ex_muldiv_pkg.sv
// Shared M-extension definitions: funct3 operation codes, sequencer states
// and operand-signedness helpers used by the multiply/divide unit.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    EXE_MUL    = 3'd0,
    EXE_MULH   = 3'd1,
    EXE_MULHSU = 3'd2,
    EXE_MULHU  = 3'd3,
    EXE_DIV    = 3'd4,
    EXE_DIVU   = 3'd5,
    EXE_REM    = 3'd6,
    EXE_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op inside {EXE_DIV, EXE_DIVU, EXE_REM, EXE_REMU};
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return op inside {EXE_REM, EXE_REMU};
  endfunction

  function automatic logic rs1_is_signed(input muldiv_op_e op);
    return op inside {EXE_MULH, EXE_MULHSU, EXE_DIV, EXE_REM};
  endfunction

  function automatic logic rs2_is_signed(input muldiv_op_e op);
    return op inside {EXE_MULH, EXE_DIV, EXE_REM};
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Restoring divider core on unsigned magnitudes, one quotient bit per step.
// Exposes next-state quotient/remainder so the caller can fix up signs on the final step.
module ex_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // quo_q starts as the dividend and shifts quotient bits in from the right
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_comb begin
    quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    rem_nxt = shifted[XLEN-1:0];
    if (!diff[XLEN]) begin
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
      rem_nxt = diff[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else if (load) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dvsr_q <= divisor;
    end else if (step) begin
      quo_q  <= quo_nxt;
      rem_q  <= rem_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: XLEN+1 cycles accept-to-result, 1 cycle for div special cases.
// Holds the pipeline via stall_req_o while busy; start_i is ignored outside IDLE, flush_i aborts.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2:0]           op_i,
  input  logic [XLEN-1:0]      reg1_i,
  input  logic [XLEN-1:0]      reg2_i,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 flush_i,
  output logic                 stall_req_o,
  output logic                 result_valid_o,
  output logic [XLEN-1:0]      result_o,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 ready_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state_q, state_d;

  muldiv_op_e             op_in, op_q;
  logic                   s1_in, s2_in, s1_q, s2_q;
  logic [XLEN-1:0]        a_mag, b_mag;
  logic                   accept, div_zero, div_ovf, special, last;
  logic [XLEN-1:0]        special_res, calc_res;
  logic [CNT_W-1:0]       cnt_q;
  logic [XLEN-1:0]        mcand_q;
  logic [2*XLEN-1:0]      prod_q, prod_nxt, prod_fix;
  logic [XLEN:0]          psum;
  logic [XLEN-1:0]        quo_nxt, rem_nxt, q_fix, r_fix;
  logic                   div_step;
  logic [XLEN-1:0]        result_q;
  logic [REGADDR_W-1:0]   wd_lat_q, wd_q;

  assign op_in  = muldiv_op_e'(op_i);
  assign accept = (state_q == MD_IDLE) && start_i && !flush_i;
  assign s1_in  = rs1_is_signed(op_in) & reg1_i[XLEN-1];
  assign s2_in  = rs2_is_signed(op_in) & reg2_i[XLEN-1];
  assign a_mag  = s1_in ? -reg1_i : reg1_i;
  assign b_mag  = s2_in ? -reg2_i : reg2_i;

  // Division corner cases resolve at accept time and skip the iteration
  assign div_zero = op_is_div(op_in) && (reg2_i == '0);
  assign div_ovf  = (op_in == EXE_DIV || op_in == EXE_REM) &&
                    (reg1_i == MIN_NEG) && (reg2_i == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op_is_rem(op_in) ? reg1_i : '1;
    end else if (div_ovf) begin
      special_res = op_is_rem(op_in) ? '0 : reg1_i;
    end
  end

  assign last = (cnt_q == CNT_W'(XLEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= MD_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = special ? MD_DONE : MD_CALC;
      MD_CALC: if (last) state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) state_d = MD_IDLE;
  end

  // Shift-add: add multiplicand into the high half when the current LSB is set
  assign psum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
  assign prod_nxt = prod_q[0] ? {psum, prod_q[XLEN-1:1]}
                              : {1'b0, prod_q[2*XLEN-1:1]};
  assign prod_fix = (s1_q ^ s2_q) ? -prod_nxt : prod_nxt;
  assign q_fix    = (s1_q ^ s2_q) ? -quo_nxt : quo_nxt;
  assign r_fix    = s1_q ? -rem_nxt : rem_nxt;

  always_comb begin
    calc_res = '0;
    case (op_q)
      EXE_MUL:                         calc_res = prod_fix[XLEN-1:0];
      EXE_MULH, EXE_MULHSU, EXE_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
      EXE_DIV, EXE_DIVU:               calc_res = q_fix;
      EXE_REM, EXE_REMU:               calc_res = r_fix;
      default:                         calc_res = '0;
    endcase
  end

  assign div_step = (state_q == MD_CALC) && op_is_div(op_q) && !flush_i;

  ex_div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= EXE_MUL;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      wd_lat_q <= '0;
      result_q <= '0;
      wd_q     <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      s1_q     <= s1_in;
      s2_q     <= s2_in;
      mcand_q  <= a_mag;
      prod_q   <= {{XLEN{1'b0}}, b_mag};
      cnt_q    <= '0;
      wd_lat_q <= wd_i;
      if (special) begin
        result_q <= special_res;
        wd_q     <= wd_i;
      end
    end else if (state_q == MD_CALC && !flush_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (!op_is_div(op_q)) prod_q <= prod_nxt;
      // Output registers only move on entry to DONE, so they hold otherwise
      if (last) begin
        result_q <= calc_res;
        wd_q     <= wd_lat_q;
      end
    end
  end

  assign ready_o        = (state_q == MD_IDLE);
  assign result_valid_o = (state_q == MD_DONE);
  assign stall_req_o    = rst && (((state_q == MD_IDLE) && start_i) || (state_q == MD_CALC));
  assign result_o       = result_q;
  assign wd_o           = wd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, flush/reset sequences,
// and randomized operations against an arithmetic reference model.
module tb_ex_muldiv;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start_i = 1'b0;
  logic [2:0]      op_i = '0;
  logic [XLEN-1:0] reg1_i = '0;
  logic [XLEN-1:0] reg2_i = '0;
  logic [RW-1:0]   wd_i = '0;
  logic            flush_i = 1'b0;
  logic            stall_req_o, result_valid_o, ready_o;
  logic [XLEN-1:0] result_o;
  logic [RW-1:0]   wd_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(XLEN), .REGADDR_W(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .op_i           (op_i),
    .reg1_i         (reg1_i),
    .reg2_i         (reg2_i),
    .wd_i           (wd_i),
    .flush_i        (flush_i),
    .stall_req_o    (stall_req_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .wd_o           (wd_o),
    .ready_o        (ready_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: full-width arithmetic straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a64, b64, p;
    int sa, sb;
    if (op < 3'd4) begin
      a64 = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
      b64 = (op == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
      p   = a64 * b64;
      return (op == 3'd0) ? p[31:0] : p[63:32];
    end
    if (b == 32'h0) return (op == 3'd4 || op == 3'd5) ? 32'hFFFF_FFFF : a;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == 3'd4) ? a : 32'h0;
    sa = a;
    sb = b;
    case (op)
      3'd4:    return 32'(sa / sb);
      3'd5:    return a / b;
      3'd6:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 32'h0 ||
        ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return XLEN + 1;
  endfunction

  // Holds start_i like a stalled EX stage would, until the result cycle
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [RW-1:0] wd, input logic [31:0] exp, input int exp_lat,
                       input string name);
    int k;
    int stalls;
    bit seen;
    @(negedge clk);
    start_i = 1'b1; op_i = op; reg1_i = a; reg2_i = b; wd_i = wd;
    k = 0; stalls = 0; seen = 1'b0;
    while (k < 80 && !seen) begin
      #1;
      if (stall_req_o) stalls++;
      if (k == 5 && exp_lat > 1) chk({name, "_busy_ready"}, 64'(ready_o), 64'd0);
      if (result_valid_o) begin
        seen = 1'b1;
        chk({name, "_lat"}, 64'(k), 64'(exp_lat));
        chk({name, "_res"}, 64'(result_o), 64'(exp));
        chk({name, "_wd"}, 64'(wd_o), 64'(wd));
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
    chk({name, "_stall"}, 64'(stalls), 64'(exp_lat));
    start_i = 1'b0;
    @(negedge clk);
    #1;
    chk({name, "_idle_ready"}, 64'(ready_o), 64'd1);
    chk({name, "_hold"}, 64'(result_o), 64'(exp));
  endtask

  initial begin
    int pulses;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [RW-1:0] wd;
    int sel;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};

    #2;
    chk("rst_stall", 64'(stall_req_o), 64'd0);
    chk("rst_valid", 64'(result_valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_wd", 64'(wd_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, RW'(i + 1), vecs[i].exp, vecs[i].lat,
            $sformatf("vec%0d", i));

    // Flush on the 10th CALC cycle
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; reg1_i = 32'h0001_2345; reg2_i = 32'h777; wd_i = 5'd20;
    repeat (10) @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_ready", 64'(ready_o), 64'd1);
    chk("flush_stall", 64'(stall_req_o), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (result_valid_o) pulses++;
    end
    chk("flush_no_valid", 64'(pulses), 64'd0);
    do_op(3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 33, "post_flush_mul");

    // Flush together with start in IDLE is not an accept
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; reg1_i = 32'd9; reg2_i = 32'd0; wd_i = 5'd3;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("flush_start_ready", 64'(ready_o), 64'd1);
    chk("flush_start_valid", 64'(result_valid_o), 64'd0);

    // Reset on the 5th CALC cycle
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd1; reg1_i = 32'h1234_5678; reg2_i = 32'h9ABC_DEF0; wd_i = 5'd17;
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", 64'(stall_req_o), 64'd0);
    chk("mid_rst_valid", 64'(result_valid_o), 64'd0);
    chk("mid_rst_result", 64'(result_o), 64'd0);
    chk("mid_rst_wd", 64'(wd_o), 64'd0);
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (result_valid_o) pulses++;
    end
    chk("mid_rst_no_valid", 64'(pulses), 64'd0);
    do_op(3'd7, 32'd1000, 32'd33, 5'd30, 32'd10, 33, "post_rst_remu");

    for (int n = 0; n < 150; n++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      wd  = RW'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 5));
      else if (sel == 3) a = 32'($urandom_range(0, 20));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(op, a, b, wd, model(op, a, b), model_lat(op, a, b), $sformatf("rnd%0d_op%0d", n, op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
